// File: rtl/p2s_pkg.sv
// Shared types and helpers for the p2s transmit scheduler.
// rr_pick performs the round-robin search over a zero-extended request vector.
package p2s_pkg;

  localparam int unsigned P2S_WIDTH = 10;
  localparam int unsigned RR_MAX    = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    SHIFT = S_SHIFT,
    GAP   = S_GAP
  } state_e;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // Search starts at ptr and wraps at n; only the first n bits of valid are examined.
  function automatic pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                    input int unsigned ptr,
                                    input int unsigned n);
    pick_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      int unsigned j;
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && valid[j[4:0]]) begin
        r.found = 1'b1;
        r.idx   = j[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/p2s_shreg.sv
// WIDTH-bit left shift register with parallel load and zero serial-in.
// The serial output is the MSB.
module p2s_shreg #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge Clock) begin
    if (rst)           q <= '0;
    else if (load)     q <= d;
    else if (shift_en) q <= {q[WIDTH-2:0], 1'b0};
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/p2s_tx_sched.sv
// Round-robin transmit scheduler: grants one word, shifts it out MSB first,
// then holds an inter-frame gap before the next grant.
module p2s_tx_sched
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH      = P2S_WIDTH,
  parameter int unsigned NREQ       = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                    Clock,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    ser_stall,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    ser_last,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(WIDTH);
  localparam logic [3:0]  GAP_INIT = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e            state;
  logic [CW-1:0]     bitcnt;
  logic [3:0]        gapcnt;
  logic [IDW-1:0]    rr_ptr;
  logic [RR_MAX-1:0] valid_ext;
  pick_t             pick;
  logic [IDW-1:0]    g;
  logic              accept;
  logic              shift_en;
  logic              msb;
  logic [WIDTH-1:0]  load_word;

  always_comb begin
    valid_ext = '0;
    valid_ext[NREQ-1:0] = req_valid;
    pick = rr_pick(valid_ext, 32'(rr_ptr), NREQ);
  end

  assign g         = IDW'(pick.idx);
  assign accept    = (state == IDLE) && pick.found;
  assign load_word = req_data[int'(g)*WIDTH +: WIDTH];
  assign shift_en  = (state == SHIFT) && !ser_stall;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (accept && (32'(g) == i)) req_ready[i] = 1'b1;
    end
  end

  p2s_shreg #(.WIDTH(WIDTH)) u_shreg (
    .Clock    (Clock),
    .rst      (rst),
    .load     (accept),
    .shift_en (shift_en),
    .d        (load_word),
    .msb      (msb)
  );

  assign ser_out   = (state == SHIFT) ? msb : 1'b0;
  assign ser_valid = shift_en;
  assign ser_last  = shift_en && (bitcnt == '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (rst) begin
      state    <= IDLE;
      bitcnt   <= '0;
      gapcnt   <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            bitcnt   <= CW'(WIDTH - 1);
            grant_id <= g;
            rr_ptr   <= (32'(g) == NREQ - 1) ? '0 : g + IDW'(1);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!ser_stall) begin
            if (bitcnt == '0) begin
              gapcnt <= GAP_INIT;
              state  <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
              bitcnt <= bitcnt - CW'(1);
            end
          end
        end
        GAP: begin
          if (gapcnt == '0) state <= IDLE;
          else              gapcnt <= gapcnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_tx_sched.sv
// Directed bench for p2s_tx_sched: main instance with a 1-cycle gap plus
// gap-0 and gap-3 instances sharing the same stimulus.
module tb_p2s_tx_sched;

  logic        Clock = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [19:0] req_data = '0;
  logic        ser_stall = 1'b0;

  logic [1:0] rdy, rdy0, rdy3;
  logic so, sv, sl, bz, so0, sv0, sl0, bz0, so3, sv3, sl3, bz3;
  logic [0:0] gid, gid0, gid3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  p2s_tx_sched #(.WIDTH(10), .NREQ(2), .GAP_CYCLES(1)) dut (
    .Clock(Clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy), .ser_stall(ser_stall), .ser_out(so), .ser_valid(sv),
    .ser_last(sl), .grant_id(gid), .busy(bz));

  p2s_tx_sched #(.WIDTH(10), .NREQ(2), .GAP_CYCLES(0)) dut0 (
    .Clock(Clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy0), .ser_stall(ser_stall), .ser_out(so0), .ser_valid(sv0),
    .ser_last(sl0), .grant_id(gid0), .busy(bz0));

  p2s_tx_sched #(.WIDTH(10), .NREQ(2), .GAP_CYCLES(3)) dut3 (
    .Clock(Clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy3), .ser_stall(ser_stall), .ser_out(so3), .ser_valid(sv3),
    .ser_last(sl3), .grant_id(gid3), .busy(bz3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [9:0] w;
    logic [9:0] got;
    int acc_prev;
    int vcount;

    // Reset state
    nxt(); nxt();
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_sv", 32'(sv), 0);
    chk("rst_so", 32'(so), 0);
    chk("rst_sl", 32'(sl), 0);
    chk("rst_busy", 32'(bz), 0);
    chk("rst_gid", 32'(gid), 0);

    // Single word
    w = 10'b1000010100;
    rst = 1'b0; req_valid = 2'b01; req_data[9:0] = w; #1;
    chk("single_ready", 32'(rdy), 32'h1);
    nxt();
    req_valid = 2'b00; #1;
    for (int i = 0; i < 10; i++) begin
      chk("single_ready_off", 32'(rdy), 0);
      chk("single_sv", 32'(sv), 1);
      chk("single_bit", 32'(so), 32'(w[9-i]));
      chk("single_last", 32'(sl), (i == 9) ? 1 : 0);
      nxt();
    end
    chk("single_gap_sv", 32'(sv), 0);
    chk("single_gap_busy", 32'(bz), 1);
    nxt();
    chk("single_idle_busy", 32'(bz), 0);

    // Contention: alternating grants, 12-cycle frame spacing
    do_reset();
    req_valid = 2'b11; req_data = {10'h001, 10'h3FF}; #1;
    acc_prev = 0;
    for (int f = 0; f < 4; f++) begin
      w = (f % 2 == 1) ? 10'h001 : 10'h3FF;
      chk("cont_ready", 32'(rdy), (f % 2 == 1) ? 32'h2 : 32'h1);
      if (f > 0) chk("cont_spacing", 32'(cyc - acc_prev), 12);
      acc_prev = cyc;
      nxt();
      chk("cont_gid", 32'(gid), 32'(f % 2));
      got = '0;
      for (int b = 0; b < 10; b++) begin
        got = {got[8:0], so};
        nxt();
      end
      chk("cont_word", 32'(got), 32'(w));
      nxt();
    end

    // Stall after 4th bit
    req_valid = 2'b00; nxt(); nxt();
    do_reset();
    w = 10'h2AA;
    req_valid = 2'b01; req_data[9:0] = w; #1;
    nxt();
    req_valid = 2'b00; #1;
    vcount = 0;
    for (int b = 0; b < 4; b++) begin
      vcount += int'(sv);
      chk("stall_pre_bit", 32'(so), 32'(w[9-b]));
      nxt();
    end
    ser_stall = 1'b1; #1;
    for (int s = 0; s < 3; s++) begin
      vcount += int'(sv);
      chk("stall_sv", 32'(sv), 0);
      chk("stall_so", 32'(so), 1);
      chk("stall_last", 32'(sl), 0);
      chk("stall_busy", 32'(bz), 1);
      nxt();
    end
    ser_stall = 1'b0; #1;
    for (int b = 4; b < 10; b++) begin
      vcount += int'(sv);
      chk("stall_post_bit", 32'(so), 32'(w[9-b]));
      chk("stall_post_last", 32'(sl), (b == 9) ? 1 : 0);
      nxt();
    end
    chk("stall_valid_bits", 32'(vcount), 10);
    chk("stall_in_gap_sv", 32'(sv), 0);
    chk("stall_in_gap_busy", 32'(bz), 1);
    nxt();

    // Reset mid-frame
    req_valid = 2'b01; req_data[9:0] = 10'h3FF; #1;
    nxt();
    req_valid = 2'b00; #1;
    for (int b = 0; b < 5; b++) nxt();
    rst = 1'b1; req_valid = 2'b11; req_data = {10'h155, 10'h3FF}; #1;
    nxt();
    chk("midrst_sv", 32'(sv), 0);
    chk("midrst_busy", 32'(bz), 0);
    rst = 1'b0; #1;
    chk("midrst_ready", 32'(rdy), 32'h1);
    nxt();
    chk("midrst_gid", 32'(gid), 0);
    req_valid = 2'b00; #1;

    // Gap boundaries on the GAP_CYCLES=0 and =3 instances
    do_reset();
    req_valid = 2'b01; req_data[9:0] = 10'h3FF; #1;
    for (int t = 0; t < 15; t++) begin
      chk("gap0_ready", 32'(rdy0), (t % 11 == 0) ? 32'h1 : 0);
      chk("gap0_sv", 32'(sv0), (t % 11 == 0) ? 0 : 1);
      chk("gap3_ready", 32'(rdy3), (t == 0 || t == 14) ? 32'h1 : 0);
      chk("gap3_sv", 32'(sv3), (t >= 1 && t <= 10) ? 1 : 0);
      chk("gap3_busy", 32'(bz3), (t >= 1 && t <= 13) ? 1 : 0);
      nxt();
    end
    chk("gap3_accept", 32'(sv3), 1);

    // Withdrawn request during SHIFT
    req_valid = 2'b00;
    do_reset();
    req_valid = 2'b01; req_data = {10'h0F0, 10'h3FF}; #1;
    nxt();
    req_valid = 2'b00; #1;
    for (int t = 0; t < 13; t++) begin
      if (t == 3) begin req_valid = 2'b10; #1; end
      if (t == 4) begin req_valid = 2'b00; #1; end
      chk("wd_ready", 32'(rdy), 0);
      nxt();
    end
    chk("wd_gid", 32'(gid), 0);
    chk("wd_idle_busy", 32'(bz), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
